ysyx_22041071_mem_arbiter: RTL



---
 rtl/ysyx_22041071_pkg.sv | 31 +++
 rtl/ysyx_22041071_arb_grant.sv | 46 ++++
 rtl/ysyx_22041071_mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_pkg.sv
// Shared types for the CPU-side memory arbiter: FSM encoding, owner tag, response and size codes.
package ysyx_22041071_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] SIZE_1B = 2'b00;
    localparam logic [1:0] SIZE_2B = 2'b01;
    localparam logic [1:0] SIZE_4B = 2'b10;
    localparam logic [1:0] SIZE_8B = 2'b11;

    localparam int GNT_IF = 0;
    localparam int GNT_LS = 1;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22041071_arb_grant.sv
// LSU-priority grant select with an IF anti-starvation counter; combinational one-hot grant,
// counter advances only on the grant strobe so a stalled bus never ages the count.
module ysyx_22041071_arb_grant
    import ysyx_22041071_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       if_valid,
    input  logic       ls_valid,
    input  logic       grant,
    output logic [1:0] gnt
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;
    logic             if_win;
    logic             ls_win;

    always_comb begin
        if_win      = if_valid && (!ls_valid || (starve_cnt == CNT_MAX));
        ls_win      = ls_valid && !if_win;
        gnt         = '0;
        gnt[GNT_IF] = if_win;
        gnt[GNT_LS] = ls_win;
    end

    // Only LSU wins taken over a waiting IF count; anything else restarts the window.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (ls_win && if_valid) begin
                if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ysyx_22041071_mem_arbiter.sv
// Shares the cpu_* port between IF and LSU one whole transaction at a time; ready in the request
// cycle, downstream valid one cycle later, responses pass through combinationally; requesters stall until granted.
module ysyx_22041071_mem_arbiter
    import ysyx_22041071_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic [LEN_W-1:0]  if_req_len,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_last,
    output logic              if_rsp_err,

    input  logic              ls_req_valid,
    input  logic              ls_req_we,
    input  logic [ADDR_W-1:0] ls_req_addr,
    input  logic [LEN_W-1:0]  ls_req_len,
    input  logic [1:0]        ls_req_size,
    input  logic [DATA_W-1:0] ls_req_wdata,
    output logic              ls_req_ready,
    output logic              ls_rsp_valid,
    output logic [DATA_W-1:0] ls_rsp_data,
    output logic              ls_rsp_last,
    output logic              ls_rsp_err,

    output logic              cpu_ar_valid,
    output logic              cpu_aw_valid,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [LEN_W-1:0]  cpu_len,
    output logic [1:0]        cpu_size,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              cpu_ar_ready,
    input  logic              cpu_aw_ready,
    input  logic              cpu_r_valid,
    input  logic [DATA_W-1:0] cpu_r_data,
    input  logic [1:0]        cpu_resp
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    owner_t            owner;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_cnt;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] data_q;
    logic              ar_valid_q;
    logic              aw_valid_q;
    logic [1:0]        gnt;
    logic              grant;
    logic              beat_last;
    logic              rsp_err;
    logic              rd_beat;
    logic              wr_done;

    assign grant     = !reset && (state == ST_IDLE) && (if_req_valid || ls_req_valid);
    assign beat_last = (beat_cnt == len_q);
    assign rsp_err   = resp_is_err(cpu_resp);
    assign rd_beat   = !reset && (state == ST_RD_DATA) && cpu_r_valid;
    assign wr_done   = !reset && (state == ST_WR) && cpu_aw_ready;

    ysyx_22041071_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .clock    (clock),
        .reset    (reset),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .grant    (grant),
        .gnt      (gnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = (gnt[GNT_LS] && ls_req_we) ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_RD_ADDR: if (cpu_ar_ready)              state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (cpu_r_valid && beat_last)  state_nxt = ST_IDLE;
            ST_WR:      if (cpu_aw_ready)              state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase

        if_req_ready = grant && gnt[GNT_IF];
        ls_req_ready = grant && gnt[GNT_LS];

        if_rsp_valid = 1'b0;
        if_rsp_data  = '0;
        if_rsp_last  = 1'b0;
        if_rsp_err   = 1'b0;
        ls_rsp_valid = 1'b0;
        ls_rsp_data  = '0;
        ls_rsp_last  = 1'b0;
        ls_rsp_err   = 1'b0;

        // Read beats go to whoever owns the burst; the other port stays quiet.
        if (rd_beat && (owner == OWN_IF)) begin
            if_rsp_valid = 1'b1;
            if_rsp_data  = cpu_r_data;
            if_rsp_last  = beat_last;
            if_rsp_err   = rsp_err;
        end
        if (rd_beat && (owner == OWN_LS)) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_data  = cpu_r_data;
            ls_rsp_last  = beat_last;
            ls_rsp_err   = rsp_err;
        end
        if (wr_done) begin
            ls_rsp_valid = 1'b1;
            ls_rsp_last  = 1'b1;
            ls_rsp_err   = rsp_err;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner      <= OWN_IF;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            data_q     <= '0;
            beat_cnt   <= '0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
        end else begin
            ar_valid_q <= (state_nxt == ST_RD_ADDR);
            aw_valid_q <= (state_nxt == ST_WR);
            if (grant) begin
                if (gnt[GNT_LS]) begin
                    owner  <= OWN_LS;
                    addr_q <= ls_req_addr;
                    len_q  <= ls_req_we ? '0 : ls_req_len;
                    size_q <= ls_req_size;
                    data_q <= ls_req_we ? ls_req_wdata : '0;
                end else begin
                    owner  <= OWN_IF;
                    addr_q <= if_req_addr;
                    len_q  <= if_req_len;
                    size_q <= SIZE_8B;
                    data_q <= '0;
                end
            end
            if ((state == ST_RD_ADDR) && cpu_ar_ready) begin
                beat_cnt <= '0;
            end else if (rd_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign cpu_ar_valid = ar_valid_q;
    assign cpu_aw_valid = aw_valid_q;
    assign cpu_addr     = addr_q;
    assign cpu_len      = len_q;
    assign cpu_size     = size_q;
    assign cpu_data     = data_q;

endmodule
